// File: rtl/wb_demux.sv
// Writeback steering stage: routes each accepted result to either the register-file
// write port or the data-memory store port, and counts cycles lost to store back-pressure.
module wb_demux #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_sel,
    input  logic [WIDTH-1:0]      in_dest,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WIDTH-1:0]      rf_wdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [WIDTH-1:0]      mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic [15:0]           stall_cnt
);

    // Each state is one-hot on the output-valid pair {mem_valid, rf_we}.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RF   = 2'b01,
        S_MEM  = 2'b10
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [REG_ADDR_W-1:0] r_rf_waddr;
    logic [WIDTH-1:0]      r_rf_wdata;
    logic [WIDTH-1:0]      r_mem_addr;
    logic [WIDTH-1:0]      r_mem_wdata;
    logic [15:0]           r_stall_cnt;

    logic                  w_mem_pend;
    logic                  w_accept;
    logic                  w_idx_nz;
    logic                  w_load_rf;
    logic                  w_load_mem;
    logic                  w_stall;

    assign w_mem_pend = (r_state == S_MEM);
    assign in_ready   = !w_mem_pend || mem_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_idx_nz   = |in_dest[REG_ADDR_W-1:0];
    assign w_load_rf  = w_accept && !in_sel && w_idx_nz;
    assign w_load_mem = w_accept && in_sel;
    assign w_stall    = w_mem_pend && !mem_ready;

    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_load_mem) begin
            w_state_nxt = S_MEM;
        end else if (w_load_rf) begin
            w_state_nxt = S_RF;
        end else if (w_stall) begin
            w_state_nxt = S_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload registers load only on their own accept so they hold while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_load_rf) begin
                r_rf_waddr <= in_dest[REG_ADDR_W-1:0];
                r_rf_wdata <= in_data;
            end
            if (w_load_mem) begin
                r_mem_addr  <= in_dest;
                r_mem_wdata <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign rf_we     = (r_state == S_RF);
    assign mem_valid = w_mem_pend;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_wb_demux.sv
// Scoreboard bench for wb_demux: stimulus queues expected retirements in accept order,
// a negedge monitor checks outputs, handshake, ordering and the stall counter.
module tb_wb_demux;

    localparam int WIDTH      = 16;
    localparam int REG_ADDR_W = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  in_sel;
    logic [WIDTH-1:0]      in_dest;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [WIDTH-1:0]      rf_wdata;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [WIDTH-1:0]      mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [15:0]           stall_cnt;

    wb_demux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_dest   (in_dest),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        int unsigned addr;
        int unsigned data;
        int unsigned due;
    } item_t;

    item_t       q[$];
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned exp_stall = 0;
    int unsigned last_waddr = 0, last_wdata = 0, last_maddr = 0, last_mdata = 0;
    bit          rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: outputs retire strictly in accept order; a store is outstanding
    // from its due cycle until a cycle with mem_ready=1.
    always @(negedge clk) begin
        bit outstanding;
        bit rf_due;
        if (!rst_n) begin
            q.delete();
            exp_stall  = 0;
            last_waddr = 0;
            last_wdata = 0;
            last_maddr = 0;
            last_mdata = 0;
        end else begin
            outstanding = (q.size() > 0) && q[0].is_mem && (cyc >= q[0].due);
            check("exclusive", int'(rf_we && mem_valid), 0);
            check("in_ready", int'(in_ready), int'(!outstanding || mem_ready));
            check("mem_valid", int'(mem_valid), int'(outstanding));
            check("stall_cnt", int'(stall_cnt), exp_stall);
            if (outstanding) begin
                check("mem_addr", int'(mem_addr), q[0].addr);
                check("mem_wdata", int'(mem_wdata), q[0].data);
                if (mem_ready) begin
                    last_maddr = q[0].addr;
                    last_mdata = q[0].data;
                    void'(q.pop_front());
                end else if (exp_stall < 32'hFFFF) begin
                    exp_stall++;
                end
            end else begin
                check("mem_addr_hold", int'(mem_addr), last_maddr);
                check("mem_wdata_hold", int'(mem_wdata), last_mdata);
            end
            rf_due = (q.size() > 0) && !q[0].is_mem && (q[0].due == cyc);
            check("rf_we", int'(rf_we), int'(rf_due));
            if (rf_due) begin
                check("rf_waddr", int'(rf_waddr), q[0].addr);
                check("rf_wdata", int'(rf_wdata), q[0].data);
                last_waddr = q[0].addr;
                last_wdata = q[0].data;
                void'(q.pop_front());
            end else begin
                check("rf_waddr_hold", int'(rf_waddr), last_waddr);
                check("rf_wdata_hold", int'(rf_wdata), last_wdata);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 mem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input bit sel, input int unsigned dest, input int unsigned data);
        bit    got;
        item_t it;
        in_valid = 1'b1;
        in_sel   = sel;
        in_dest  = dest[WIDTH-1:0];
        in_data  = data[WIDTH-1:0];
        got      = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout at cycle %0d: got in_ready=0, expected 1", cyc);
        end else begin
            it.is_mem = sel;
            it.addr   = sel ? (dest & 32'hFFFF) : (dest % 8);
            it.data   = data & 32'hFFFF;
            it.due    = cyc + 1;
            if (sel || (dest % 8) != 0) q.push_back(it);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 1'b0;
        in_dest   = '0;
        in_data   = '0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b0, 3, 16'h1234);
        issue(1'b0, 5, 16'hBEEF);
        issue(1'b0, 0, 16'h7777);
        issue(1'b0, 16'hFFF9, 16'h0042);
        repeat (2) @(posedge clk);
        #1;

        mem_ready = 1'b0;
        issue(1'b1, 16'h0040, 16'hA5A5);
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
        @(negedge clk);
        check("stall_after_3", int'(stall_cnt), 3);
        @(posedge clk);
        #1;

        mem_ready = 1'b0;
        issue(1'b1, 16'h0100, 16'h5A5A);
        fork
            issue(1'b0, 2, 16'hC0DE);
            begin
                repeat (2) @(posedge clk);
                #1 mem_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        mem_ready = 1'b1;
        issue(1'b1, 16'h0010, 16'h1111);
        issue(1'b1, 16'h0011, 16'h2222);
        issue(1'b1, 16'h0012, 16'h3333);
        repeat (2) @(posedge clk);
        #1;

        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            issue($urandom_range(0, 1) == 1, $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        mem_ready = 1'b0;
        issue(1'b1, 16'h0200, 16'hDEAD);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("stall_saturated", int'(stall_cnt), 32'hFFFF);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mem_valid_after_reset", int'(mem_valid), 0);
        check("stall_after_reset", int'(stall_cnt), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
